// File: rtl/piano_key_encoder.sv
// Piano front end: synchronises and debounces 8 note keys plus an octave key,
// latches one held note with valid/strobe, and steps a 2-bit octave counter.
module piano_key_encoder #(
   parameter int DEB_CYCLES = 20000,
   parameter int CNT_W      = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] key_in,
   input  logic       oct_key,
   output logic [2:0] note_code,
   output logic       note_valid,
   output logic       note_strobe,
   output logic [1:0] oct_code
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HELD = 2'b01
   } state_t;

   logic [8:0]       sync1_q;
   logic [8:0]       sync2_q;
   logic [8:0]       stable_q;
   logic [CNT_W-1:0] cnt_q [9];
   logic             octPrev_q;
   logic [1:0]       oct_q;
   logic [1:0]       oct_d;

   state_t           state_q;
   state_t           state_d;
   logic [2:0]       code_q;
   logic [2:0]       code_d;
   logic             valid_q;
   logic             valid_d;
   logic             strobe_q;
   logic             strobe_d;
   logic [2:0]       lowIdx;

   // Bit 8 carries the octave key so all nine inputs share one sync/debounce path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < 9; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= {oct_key, key_in};
         sync2_q <= sync1_q;
         for (int i = 0; i < 9; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
               stable_q[i] <= sync2_q[i];
               cnt_q[i]    <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      lowIdx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (stable_q[i]) lowIdx = 3'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      valid_d  = valid_q;
      strobe_d = 1'b0;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (|stable_q[7:0]) begin
               code_d   = lowIdx;
               valid_d  = 1'b1;
               strobe_d = 1'b1;
               state_d  = HELD;
            end
         end
         HELD: begin
            if (!stable_q[code_q]) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign oct_d = (stable_q[8] && !octPrev_q) ? oct_q + 2'd1 : oct_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         code_q    <= '0;
         valid_q   <= 1'b0;
         strobe_q  <= 1'b0;
         octPrev_q <= 1'b0;
         oct_q     <= '0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         strobe_q  <= strobe_d;
         octPrev_q <= stable_q[8];
         oct_q     <= oct_d;
      end
   end

   assign note_code   = code_q;
   assign note_valid  = valid_q;
   assign note_strobe = strobe_q;
   assign oct_code    = oct_q;

endmodule
